cbb_ecc_dec: RTL and testbench

//  SECDED decoder paired with cbb_ecc_enc: takes {ecc, data} codewords and recomputes the Hamming syndrome

---
 rtl/cbb_ecc_pkg.sv | 58 +++++
 rtl/cbb_ecc_if.sv | 31 +++
 rtl/cbb_ecc_syn.sv | 27 ++
 rtl/cbb_ecc_dec.sv | 123 ++++++++++++
 tb/tb_cbb_ecc_dec.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cbb_ecc_pkg.sv
// Shared SECDED definitions for the cbb_ecc encoder/decoder pair: generator matrix and sizing helpers.
// Data bit i sits at the i-th non-power-of-two Hamming position (3,5,6,7,9,...), which is its syndrome column.
package cbb_ecc_pkg;

  localparam int G_ROWS = 9;
  localparam int G_COLS = 256;
  localparam int DW_MAX = 247;

  typedef logic [0:G_ROWS-1][G_COLS-1:0] g_matrix_t;

  // Syndrome column (Hamming position) of data bit i.
  function automatic logic [7:0] ecc_col(input int i);
    int n;
    logic [7:0] col;
    n   = 0;
    col = '0;
    for (int p = 3; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) col = 8'(p);
        n++;
      end
    end
    return col;
  endfunction

  // Check bits (Hamming bits plus overall parity) needed for dw data bits.
  function automatic int ecc_ew(input int dw);
    int  res;
    bit  found;
    res   = 0;
    found = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      if (!found && ((1 << r) >= dw + r + 1)) begin
        res   = r + 1;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Row g holds bit g of every data column; row 8 is reserved and left zero.
  function automatic g_matrix_t build_g();
    g_matrix_t m;
    int        n;
    m = '0;
    n = 0;
    for (int p = 3; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int g = 0; g < 8; g++) m[g][n] = p[g];
        n++;
      end
    end
    return m;
  endfunction

  localparam g_matrix_t G_MATRIX = build_g();

endpackage

// File: rtl/cbb_ecc_if.sv
// Decoder bus: codeword input, corrected output with flags, and status counters/log.
interface cbb_ecc_if #(
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int CW = 16
);
  logic              din_vld;
  logic [DW+EW-1:0]  din;
  logic              cnt_clr;
  logic              dout_vld;
  logic [DW-1:0]     dout;
  logic              err_1bit;
  logic              err_2bit;
  logic [EW-2:0]     syndrome;
  logic [CW-1:0]     sb_cnt;
  logic [CW-1:0]     db_cnt;
  logic              log_vld;
  logic [EW-1:0]     log_syn;

  modport master (
    output din_vld, din, cnt_clr,
    input  dout_vld, dout, err_1bit, err_2bit, syndrome,
    input  sb_cnt, db_cnt, log_vld, log_syn
  );

  modport slave (
    input  din_vld, din, cnt_clr,
    output dout_vld, dout, err_1bit, err_2bit, syndrome,
    output sb_cnt, db_cnt, log_vld, log_syn
  );
endinterface

// File: rtl/cbb_ecc_syn.sv
// Combinational Hamming syndrome and overall parity of a {ecc, data} codeword.
module cbb_ecc_syn
  import cbb_ecc_pkg::*;
#(
  parameter int DW = 32,
  parameter int EW = 7
) (
  input  logic [DW+EW-1:0] cw,
  output logic [EW-2:0]    syn,
  output logic             par
);

  logic [DW-1:0] data;

  assign data = cw[DW-1:0];

  always_comb begin
    syn = '0;
    for (int g = 0; g < EW - 1; g++) begin
      syn[g] = (^(data & G_MATRIX[g][DW-1:0])) ^ cw[DW+g];
    end
  end

  // Covers every bit including the overall parity bit, so a clean word gives 0.
  assign par = ^cw;

endmodule

// File: rtl/cbb_ecc_dec.sv
// SECDED decoder: 2-stage pipeline, single-error correction, double-error detection,
// saturating error counters and a first-error log.
module cbb_ecc_dec
  import cbb_ecc_pkg::*;
#(
  parameter int DW = 32,
  parameter int EW = 7,
  parameter int CW = 16
) (
  input logic      clk,
  input logic      rst_n,
  cbb_ecc_if.slave bus
);

  if (DW < 1 || DW > DW_MAX || EW < ecc_ew(DW) || EW > G_ROWS) begin : g_param_chk
    $fatal(1, "cbb_ecc_dec: EW too small for DW or DW out of range");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [EW-2:0] syn_c;
  logic          par_c;

  cbb_ecc_syn #(.DW(DW), .EW(EW)) u_syn (
    .cw  (bus.din),
    .syn (syn_c),
    .par (par_c)
  );

  // ---- stage 1: syndrome / parity register ----
  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic [EW-2:0] syn_p1;
  logic          par_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      syn_p1  <= '0;
      par_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.din_vld;
      if (bus.din_vld) begin
        data_p1 <= bus.din[DW-1:0];
        syn_p1  <= syn_c;
        par_p1  <= par_c;
      end
    end
  end

  // ---- stage 2: correction and classification ----
  logic [DW-1:0] flip;

  for (genvar i = 0; i < DW; i++) begin : g_col
    localparam logic [7:0] COL = ecc_col(i);
    assign flip[i] = par_p1 && (syn_p1 == COL[EW-2:0]);
  end

  logic          vld_p2;
  logic [DW-1:0] dout_p2;
  logic          err1_p2;
  logic          err2_p2;
  logic [EW-2:0] syn_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      dout_p2 <= '0;
      err1_p2 <= 1'b0;
      err2_p2 <= 1'b0;
      syn_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        dout_p2 <= data_p1 ^ flip;
        err1_p2 <= par_p1;
        err2_p2 <= !par_p1 && (syn_p1 != '0);
        syn_p2  <= syn_p1;
      end
    end
  end

  // ---- status: counters and first-error log fed by the stage-2 output ----
  logic [CW-1:0] sb_cnt_q;
  logic [CW-1:0] db_cnt_q;
  logic          log_vld_q;
  logic [EW-1:0] log_syn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      log_vld_q <= 1'b0;
      log_syn_q <= '0;
    end else if (bus.cnt_clr) begin
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      log_vld_q <= 1'b0;
      log_syn_q <= '0;
    end else if (vld_p2) begin
      if (err1_p2) sb_cnt_q <= sat_inc(sb_cnt_q);
      if (err2_p2) db_cnt_q <= sat_inc(db_cnt_q);
      if (!log_vld_q && (err1_p2 || err2_p2)) begin
        log_vld_q <= 1'b1;
        log_syn_q <= {err2_p2, syn_p2};
      end
    end
  end

  assign bus.dout_vld = vld_p2;
  assign bus.dout     = dout_p2;
  assign bus.err_1bit = err1_p2;
  assign bus.err_2bit = err2_p2;
  assign bus.syndrome = syn_p2;
  assign bus.sb_cnt   = sb_cnt_q;
  assign bus.db_cnt   = db_cnt_q;
  assign bus.log_vld  = log_vld_q;
  assign bus.log_syn  = log_syn_q;

endmodule

// File: tb/tb_cbb_ecc_dec.sv
// Directed bench for cbb_ecc_dec: reference encoder, scoreboard on the CW=16 instance,
// saturation/clear/reset-flush steps on a CW=4 instance.
module tb_cbb_ecc_dec;

  localparam int DW = 32;
  localparam int EW = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cbb_ecc_if #(.DW(DW), .EW(EW), .CW(16)) bus ();
  cbb_ecc_if #(.DW(DW), .EW(EW), .CW(4))  bus4 ();

  cbb_ecc_dec #(.DW(DW), .EW(EW), .CW(16)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  cbb_ecc_dec #(.DW(DW), .EW(EW), .CW(4))  dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

  typedef struct {
    logic [31:0] data;
    logic        e1;
    logic        e2;
    logic [5:0]  syn;
    int          due;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hamming position of data bit i: the i-th integer >= 3 that is not a power of two.
  function automatic int tb_pos(input int i);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int p = 3; p < 300; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) res = p;
        n++;
      end
    end
    return res;
  endfunction

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] h;
    int         pos;
    h = '0;
    for (int i = 0; i < 32; i++) begin
      pos = tb_pos(i);
      for (int g = 0; g < 6; g++) if (((pos >> g) & 1) == 1) h[g] = h[g] ^ d[i];
    end
    return {^{h, d}, h, d};
  endfunction

  task automatic drive(input logic [38:0] cw, input logic [31:0] xd, input logic xe1,
                       input logic xe2, input logic [5:0] xsyn);
    exp_t e;
    @(negedge clk);
    bus.din_vld = 1'b1;
    bus.din     = cw;
    e.data = xd;
    e.e1   = xe1;
    e.e2   = xe2;
    e.syn  = xsyn;
    e.due  = cyc + 2;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.din_vld  = 1'b0;
      bus4.din_vld = 1'b0;
    end
  endtask

  // Scoreboard on the main instance's output.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.dout_vld === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_dout_vld", 64'(bus.dout_vld), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout",     64'(bus.dout),     64'(e.data));
        chk("err_1bit", 64'(bus.err_1bit), 64'(e.e1));
        chk("err_2bit", 64'(bus.err_2bit), 64'(e.e2));
        chk("syndrome", 64'(bus.syndrome), 64'(e.syn));
        chk("latency",  64'(cyc),          64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [38:0] cw;
    logic [31:0] d;
    logic [5:0]  xs;

    rst_n        = 1'b0;
    rst4_n       = 1'b0;
    bus.din_vld  = 1'b0;
    bus.din      = '0;
    bus.cnt_clr  = 1'b0;
    bus4.din_vld = 1'b0;
    bus4.din     = '0;
    bus4.cnt_clr = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_dout_vld", 64'(bus.dout_vld), 64'd0);
    chk("rst_dout",     64'(bus.dout),     64'd0);
    chk("rst_flags",    64'({bus.err_1bit, bus.err_2bit}), 64'd0);
    chk("rst_syndrome", 64'(bus.syndrome), 64'd0);
    chk("rst_cnts",     64'({bus.sb_cnt, bus.db_cnt}), 64'd0);
    chk("rst_log",      64'({bus.log_vld, bus.log_syn}), 64'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // Clean word
    drive(enc(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0, 6'h00);
    idle(4);
    chk("t1_sb_cnt",  64'(bus.sb_cnt),  64'd0);
    chk("t1_db_cnt",  64'(bus.db_cnt),  64'd0);
    chk("t1_log_vld", 64'(bus.log_vld), 64'd0);

    // Data bit 0 flipped
    cw = enc(32'hDEADBEEF);
    cw[0] = ~cw[0];
    drive(cw, 32'hDEADBEEF, 1'b1, 1'b0, 6'h03);
    idle(4);
    chk("t2_sb_cnt",  64'(bus.sb_cnt),  64'd1);
    chk("t2_log_vld", 64'(bus.log_vld), 64'd1);
    chk("t2_log_syn", 64'(bus.log_syn), 64'h03);
    chk("bubble_vld",  64'(bus.dout_vld), 64'd0);
    chk("bubble_dout", 64'(bus.dout),     64'hDEADBEEF);
    chk("bubble_e1",   64'(bus.err_1bit), 64'd1);

    // Data bit 0 and check bit 0 flipped: syndrome 3^1
    cw = enc(32'h12345678);
    cw[0]  = ~cw[0];
    cw[32] = ~cw[32];
    drive(cw, 32'h12345679, 1'b0, 1'b1, 6'h02);
    idle(4);
    chk("t3_db_cnt",  64'(bus.db_cnt),  64'd1);
    chk("t3_sb_cnt",  64'(bus.sb_cnt),  64'd1);
    chk("t3_log_keep", 64'({bus.log_vld, bus.log_syn}), 64'({1'b1, 7'h03}));

    // Overall parity bit only
    cw = enc(32'hDEADBEEF);
    cw[38] = ~cw[38];
    drive(cw, 32'hDEADBEEF, 1'b1, 1'b0, 6'h00);
    idle(4);
    chk("t4_sb_cnt", 64'(bus.sb_cnt), 64'd2);

    @(negedge clk);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    chk("clr_cnts", 64'({bus.sb_cnt, bus.db_cnt}), 64'd0);
    chk("clr_log",  64'({bus.log_vld, bus.log_syn}), 64'd0);

    // Every codeword bit flipped in turn, back-to-back
    d = 32'hC0FFEE11;
    for (int b = 0; b < 39; b++) begin
      cw = enc(d);
      cw[b] = ~cw[b];
      if (b < 32)      xs = 6'(tb_pos(b));
      else if (b < 38) xs = 6'(1 << (b - 32));
      else             xs = 6'h00;
      drive(cw, d, 1'b1, 1'b0, xs);
    end
    idle(5);
    chk("t5_sb_cnt",  64'(bus.sb_cnt),  64'd39);
    chk("t5_db_cnt",  64'(bus.db_cnt),  64'd0);
    chk("t5_log_syn", 64'(bus.log_syn), 64'h03);

    // Random clean words
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      drive(enc(d), d, 1'b0, 1'b0, 6'h00);
    end
    idle(5);
    chk("rand_sb_cnt", 64'(bus.sb_cnt), 64'd39);
    chk("sb_drained",  64'(q.size()),   64'd0);

    // CW=4: saturation
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cw = enc(32'(k * 32'h01010101));
      cw[5] = ~cw[5];
      bus4.din_vld = 1'b1;
      bus4.din     = cw;
    end
    idle(5);
    chk("sat_sb_cnt", 64'(bus4.sb_cnt), 64'd15);
    chk("sat_db_cnt", 64'(bus4.db_cnt), 64'd0);

    // CW=4: clear in the same cycle an error leaves stage 2
    @(negedge clk);
    cw = enc(32'hA5A5A5A5);
    cw[1] = ~cw[1];
    bus4.din_vld = 1'b1;
    bus4.din     = cw;
    @(negedge clk);
    bus4.din_vld = 1'b0;
    @(negedge clk);
    chk("clr_err_leaving", 64'({bus4.dout_vld, bus4.err_1bit}), 64'b11);
    bus4.cnt_clr = 1'b1;
    @(negedge clk);
    bus4.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_pri_sb_cnt",  64'(bus4.sb_cnt),  64'd0);
    chk("clr_pri_log_vld", 64'(bus4.log_vld), 64'd0);

    // CW=4: reset with words in flight
    @(negedge clk);
    bus4.din_vld = 1'b1;
    bus4.din     = enc(32'h11111111);
    @(negedge clk);
    bus4.din     = enc(32'h22222222);
    rst4_n       = 1'b0;
    @(negedge clk);
    bus4.din_vld = 1'b0;
    chk("flush_in_rst", 64'(bus4.dout_vld), 64'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_no_vld", 64'(bus4.dout_vld), 64'd0);
    end
    chk("flush_sb_cnt", 64'(bus4.sb_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
